// File: rtl/multi_channel_threshold_detector_pkg.sv
// Shared types and helpers for the multi-channel threshold detector.
package multi_channel_threshold_detector_pkg;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_DETECT = 2'd1,
    CH_HOLD   = 2'd2
  } ch_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/threshold_channel_fsm.sv
// One channel's detect/hold state; next-state outputs are combinational so the
// caller can register them alongside the update strobe.
module threshold_channel_fsm
  import multi_channel_threshold_detector_pkg::*;
#(
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd,
  input  logic              trig,
  input  logic              rel,
  input  logic [HOLD_W-1:0] holdoff,
  output logic              det_nxt,
  output logic              rise_nxt
);

  ch_state_e         state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    rise_nxt  = 1'b0;
    unique case (state)
      CH_IDLE: begin
        if (trig) begin
          state_nxt = CH_DETECT;
          rise_nxt  = 1'b1;
        end
      end
      CH_DETECT: begin
        if (rel) begin
          if (holdoff == '0) begin
            state_nxt = CH_IDLE;
          end else begin
            state_nxt = CH_HOLD;
            hold_nxt  = holdoff;
          end
        end
      end
      CH_HOLD: begin
        // The sample that exhausts the hold-off never evaluates a trigger.
        hold_nxt = hold_cnt - 1'b1;
        if (hold_cnt <= HOLD_W'(1)) begin
          state_nxt = CH_IDLE;
          hold_nxt  = '0;
        end
      end
      default: state_nxt = CH_IDLE;
    endcase
    det_nxt = (state_nxt == CH_DETECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CH_IDLE;
      hold_cnt <= '0;
    end else if (upd) begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

endmodule

// File: rtl/multi_channel_threshold_detector.sv
// Interleaved multi-channel signal-vs-noise detector with hysteresis and hold-off;
// two-stage pipeline (products, then compare/state update) that stalls as a whole.
module multi_channel_threshold_detector
  import multi_channel_threshold_detector_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int THRES_W = 12,
  parameter int GAIN    = 17,
  parameter int GAIN_W  = 5,
  parameter int NUM_CH  = 4,
  parameter int CH_W    = (NUM_CH > 1) ? clog2(NUM_CH) : 1,
  parameter int HOLD_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH_W-1:0]    in_ch,
  input  logic [DATA_W-1:0]  signal_in,
  input  logic [DATA_W-1:0]  noise_in,
  input  logic [THRES_W-1:0] thres_hi,
  input  logic [THRES_W-1:0] thres_lo,
  input  logic [HOLD_W-1:0]  holdoff,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH_W-1:0]    out_ch,
  output logic               out_det,
  output logic               out_rise,
  output logic               out_err,
  output logic [CNT_W-1:0]   evt_count,
  input  logic               cnt_clr
);

  localparam int PSIG_W = DATA_W + GAIN_W;
  localparam int PTH_W  = DATA_W + THRES_W;
  localparam int CMP_W  = (PSIG_W > PTH_W) ? PSIG_W : PTH_W;

  logic               vld_p1;
  logic [CH_W-1:0]    ch_p1;
  logic [PSIG_W-1:0]  p_sig_p1;
  logic [PTH_W-1:0]   p_hi_p1;
  logic [PTH_W-1:0]   p_lo_p1;
  logic [THRES_W-1:0] eff_lo;
  logic               adv2, fire2, err_p1, trig_p1, rel_p1;
  logic [NUM_CH-1:0]  det_nxt, rise_nxt;
  logic               det_sel, rise_sel;

  assign adv2     = !out_valid || out_ready;
  assign in_ready = !vld_p1 || adv2;
  assign fire2    = vld_p1 && adv2;
  assign eff_lo   = (thres_lo < thres_hi) ? thres_lo : thres_hi;

  // Stage 1: full-precision products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      ch_p1    <= in_ch;
      p_sig_p1 <= PSIG_W'(signal_in) * PSIG_W'(GAIN);
      p_hi_p1  <= PTH_W'(noise_in) * PTH_W'(thres_hi);
      p_lo_p1  <= PTH_W'(noise_in) * PTH_W'(eff_lo);
    end
  end

  // Stage 2: compare, per-channel state update, output register
  assign trig_p1 = CMP_W'(p_sig_p1) >  CMP_W'(p_hi_p1);
  assign rel_p1  = CMP_W'(p_sig_p1) <= CMP_W'(p_lo_p1);
  assign err_p1  = {1'b0, ch_p1} >= (CH_W + 1)'(NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    threshold_channel_fsm #(
      .HOLD_W(HOLD_W)
    ) u_fsm (
      .clk     (clk),
      .rst_n   (rst_n),
      .upd     (fire2 && (ch_p1 == CH_W'(i))),
      .trig    (trig_p1),
      .rel     (rel_p1),
      .holdoff (holdoff),
      .det_nxt (det_nxt[i]),
      .rise_nxt(rise_nxt[i])
    );
  end

  always_comb begin
    det_sel  = 1'b0;
    rise_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_p1 == CH_W'(i)) begin
        det_sel  = det_nxt[i];
        rise_sel = rise_nxt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_det   <= 1'b0;
      out_rise  <= 1'b0;
      out_err   <= 1'b0;
    end else if (adv2) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_ch   <= ch_p1;
        out_det  <= det_sel;
        out_rise <= rise_sel;
        out_err  <= err_p1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_count <= '0;
    end else if (cnt_clr) begin
      evt_count <= '0;
    end else if (fire2 && rise_sel && (evt_count != '1)) begin
      evt_count <= evt_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_channel_threshold_detector.sv
// Directed bench with a queue-based reference model of the per-channel detector.
module tb_multi_channel_threshold_detector;

  localparam int DATA_W  = 32;
  localparam int THRES_W = 12;
  localparam int HOLD_W  = 8;
  localparam int CNT_W   = 16;
  localparam int NUM_CH  = 4;
  localparam int CH_W    = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               in_valid, in_ready, out_valid, out_ready;
  logic [CH_W-1:0]    in_ch, out_ch;
  logic [DATA_W-1:0]  signal_in, noise_in;
  logic [THRES_W-1:0] thres_hi, thres_lo;
  logic [HOLD_W-1:0]  holdoff;
  logic               out_det, out_rise, out_err, cnt_clr;
  logic [CNT_W-1:0]   evt_count;

  always #5 clk = ~clk;

  multi_channel_threshold_detector dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .signal_in(signal_in), .noise_in(noise_in),
    .thres_hi(thres_hi), .thres_lo(thres_lo), .holdoff(holdoff),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_det(out_det), .out_rise(out_rise), .out_err(out_err),
    .evt_count(evt_count), .cnt_clr(cnt_clr)
  );

  typedef struct {
    logic [CH_W-1:0]  ch;
    logic             det;
    logic             rise;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   mode [NUM_CH];   // 0 idle, 1 detecting, 2 suppressed
  int   rem  [NUM_CH];   // suppressed samples still to come
  int   m_cnt;
  int   errors = 0;
  int   checks = 0;
  logic [CH_W-1:0] last_ch;
  logic last_det, last_rise;

  task automatic model_accept(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] sig,
                              input logic [DATA_W-1:0] noi);
    longint unsigned ps, ph, pl, lo;
    int c;
    exp_t e;
    c  = int'(ch);
    lo = (thres_lo < thres_hi) ? 64'(thres_lo) : 64'(thres_hi);
    ps = 64'(sig) * 64'd17;
    ph = 64'(noi) * 64'(thres_hi);
    pl = 64'(noi) * lo;
    e.ch = ch; e.rise = 1'b0; e.err = 1'b0;
    if (mode[c] == 0) begin
      if (ps > ph) begin mode[c] = 1; e.rise = 1'b1; end
    end else if (mode[c] == 1) begin
      if (ps <= pl) begin
        if (holdoff == 0) mode[c] = 0;
        else begin mode[c] = 2; rem[c] = int'(holdoff); end
      end
    end else begin
      rem[c] = rem[c] - 1;
      if (rem[c] == 0) mode[c] = 0;
    end
    e.det = (mode[c] == 1);
    if (e.rise && m_cnt < 65535) m_cnt++;
    e.cnt = CNT_W'(m_cnt);
    q.push_back(e);
  endtask

  // Compare outputs every cycle they are valid, then record any new acceptance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
      for (int i = 0; i < NUM_CH; i++) begin mode[i] = 0; rem[i] = 0; end
    end else begin
      if (cnt_clr) m_cnt = 0;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got ch=%0d with no sample outstanding", out_ch);
        end else begin
          e = q[0];
          if (out_ch !== e.ch || out_det !== e.det || out_rise !== e.rise ||
              out_err !== e.err || evt_count !== e.cnt) begin
            errors++;
            $display("FAIL result: got ch=%0d det=%0b rise=%0b err=%0b cnt=%0d, want ch=%0d det=%0b rise=%0b err=%0b cnt=%0d",
                     out_ch, out_det, out_rise, out_err, evt_count, e.ch, e.det, e.rise, e.err, e.cnt);
          end
          if (out_ready) begin
            last_ch = out_ch; last_det = out_det; last_rise = out_rise;
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) model_accept(in_ch, signal_in, noise_in);
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic send(input int ch, input logic [DATA_W-1:0] sig, input logic [DATA_W-1:0] noi);
    int  n = 0;
    bit  done = 0;
    in_valid = 1'b1; in_ch = CH_W'(ch); signal_in = sig; noise_in = noi;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        done = 1;
      end else begin
        @(posedge clk); #1;
        n++;
        if (n > 50) begin
          checks++; errors++;
          $display("FAIL send_timeout: in_ready low for %0d cycles, want accepted", n);
          done = 1;
        end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_outstanding", longint'(q.size()) + longint'(out_valid), 0);
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    in_valid = 1'b0; in_ch = '0; signal_in = '0; noise_in = '0;
    thres_hi = 12'd169; thres_lo = 12'd100; holdoff = 8'd3;
    out_ready = 1'b1; cnt_clr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_det", out_det, 0);
    check("rst_out_rise", out_rise, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_evt_count", evt_count, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Equality is not a detection; one count less threshold is.
    thres_hi = 12'd170;
    send(0, 100, 10); drain();
    check("eq_det", last_det, 0);
    check("eq_evt", evt_count, 0);
    thres_hi = 12'd169;
    send(0, 100, 10); drain();
    check("trig_det", last_det, 1);
    check("trig_rise", last_rise, 1);
    check("trig_evt", evt_count, 1);

    // Hysteresis and hold-off of 3 samples
    send(0, 60, 10); drain();
    check("hyst_hold_det", last_det, 1);
    check("hyst_hold_rise", last_rise, 0);
    send(0, 58, 10); drain();
    check("hyst_release_det", last_det, 0);
    for (int k = 0; k < 3; k++) send(0, 100, 10);
    drain();
    check("holdoff_det", last_det, 0);
    send(0, 100, 10); drain();
    check("retrig_rise", last_rise, 1);
    check("retrig_evt", evt_count, 2);

    // Interleaved channels, only ch2 above threshold
    pulse_reset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < NUM_CH; c++) send(c, (c == 2) ? 100 : 50, 10);
    drain();
    check("ilv_evt", evt_count, 1);
    check("ilv_last_ch", last_ch, 3);
    check("ilv_last_det", last_det, 0);

    // Backpressure: hold out_ready low for 5 cycles under a continuous stream
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) send(k % 4, (k % 2 != 0) ? 200 : 20, 10);
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Extremes
    pulse_reset();
    thres_hi = 12'd4095;
    send(1, 32'hFFFF_FFFF, 0); drain();
    check("ext_zero_noise_rise", last_rise, 1);
    send(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF); drain();
    check("ext_full_scale_det", last_det, 0);
    thres_hi = 12'd169; thres_lo = 12'd200;
    send(3, 100, 10); drain();
    check("lo_clamp_rise", last_rise, 1);
    send(3, 100, 10); drain();
    check("lo_clamp_stay", last_det, 1);
    send(3, 99, 10); drain();
    check("lo_clamp_release", last_det, 0);
    thres_lo = 12'd100; holdoff = 8'd0;
    send(1, 0, 5); drain();
    check("hold0_release", last_det, 0);
    send(1, 100, 10); drain();
    check("hold0_retrig", last_rise, 1);
    check("ext_evt", evt_count, 3);
    cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    check("cnt_clr", evt_count, 0);

    // Reset with two samples in flight; ch1 was detecting beforehand
    holdoff = 8'd3;
    send(0, 100, 10);
    send(2, 100, 10);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_evt", evt_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    thres_hi = 12'd170;
    send(1, 100, 10); drain();
    check("midrst_ch1_idle", last_det, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
